// File: rtl/fetch_next_pc_pkg.sv
// Shared fetch-stage definitions: RISC-V control opcodes, link registers,
// FSM states and the packet held for dispatch.
package fetch_next_pc_pkg;

    localparam int PKT_XLEN = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_T0   = 5'd5;

    typedef enum logic {
        S_REQ,
        S_VALID
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]         inst;
        logic [PKT_XLEN-1:0] PC;
        logic [PKT_XLEN-1:0] NPC;
        logic                pred_taken;
    } fetch_pkt_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/fetch_next_pc_predecode.sv
// Combinational predecode: classifies calls/returns and predicts the next PC
// for one instruction at a given PC.
module fetch_next_pc_predecode
    import fetch_next_pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_read_from_ras,
    input  logic [XLEN-1:0] i_jal_ret_addr,
    output logic            o_is_call,
    output logic            o_is_return,
    output logic [XLEN-1:0] o_npc,
    output logic            o_pred_taken
);

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_is_branch;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_jimm;
    logic [XLEN-1:0] w_bimm;

    assign w_opcode    = i_inst[6:0];
    assign w_rd        = i_inst[11:7];
    assign w_rs1       = i_inst[19:15];
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_jalr   = (w_opcode == OP_JALR);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_pc_plus4  = i_pc + XLEN'(4);

    assign w_jimm = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                     i_inst[20], i_inst[30:21], 1'b0};
    assign w_bimm = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7],
                     i_inst[30:25], i_inst[11:8], 1'b0};

    // A link write marks a call even when rs1 is also a link register.
    assign o_is_call   = (w_is_jal || w_is_jalr) && is_link(w_rd);
    assign o_is_return = w_is_jalr && (w_rd == REG_ZERO) && is_link(w_rs1) && !o_is_call;

    always_comb begin
        o_npc = w_pc_plus4;
        if (w_is_jal) begin
            o_npc = i_pc + w_jimm;
        end else if (w_is_branch && i_inst[31]) begin
            o_npc = i_pc + w_bimm;
        end else if (o_is_return && i_read_from_ras) begin
            o_npc = i_jal_ret_addr;
        end
    end

    assign o_pred_taken = (o_npc != w_pc_plus4);

endmodule

// File: rtl/fetch_next_pc.sv
// Fetch-stage next-PC generator: drives I-cache lookups, holds one predecoded
// instruction for dispatch and issues RAS push/pop once per dispatched instruction.
module fetch_next_pc
    import fetch_next_pc_pkg::*;
#(
    parameter int              XLEN     = PKT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] icache_req_addr,
    input  logic            icache_rsp_valid,
    input  logic [31:0]     icache_rsp_inst,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_inst,
    output logic [XLEN-1:0] if_PC,
    output logic [XLEN-1:0] if_NPC,
    output logic            if_pred_taken,
    output logic            ras_push_enable,
    output logic            ras_pop_enable,
    output logic [XLEN-1:0] jal_PC_plus_4,
    input  logic            read_from_ras,
    input  logic [XLEN-1:0] jal_ret_addr,
    input  logic            commit_mis_pred,
    input  logic [XLEN-1:0] commit_target_PC
);

    fetch_state_e    r_state;
    fetch_state_e    w_nxt_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_nxt_pc;
    fetch_pkt_t      r_pkt;
    logic            r_call;
    logic            r_ret;
    logic            w_capture;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_req_addr;
    logic            w_pd_call;
    logic            w_pd_ret;
    logic [XLEN-1:0] w_pd_npc;
    logic            w_pd_taken;

    fetch_next_pc_predecode #(.XLEN(XLEN)) u_predecode (
        .i_inst          (icache_rsp_inst),
        .i_pc            (w_req_addr),
        .i_read_from_ras (read_from_ras),
        .i_jal_ret_addr  (jal_ret_addr),
        .o_is_call       (w_pd_call),
        .o_is_return     (w_pd_ret),
        .o_npc           (w_pd_npc),
        .o_pred_taken    (w_pd_taken)
    );

    assign w_fire = (r_state == S_VALID) && if_ready && !commit_mis_pred;
    assign w_push = w_fire && r_call;
    assign w_pop  = w_fire && r_ret && read_from_ras;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_capture   = 1'b0;
        w_req_addr  = r_pc;
        case (r_state)
            S_REQ: begin
                if (icache_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_nxt_state = S_VALID;
                end
            end
            S_VALID: begin
                w_req_addr = w_fire ? r_pkt.NPC : r_pkt.PC;
                // After a RAS op the next prediction must see the updated top,
                // so the follow-on lookup is deferred to a fresh REQ cycle.
                if (w_fire) begin
                    if (w_push || w_pop || !icache_rsp_valid) begin
                        w_nxt_pc    = r_pkt.NPC;
                        w_nxt_state = S_REQ;
                    end else begin
                        w_capture = 1'b1;
                    end
                end
            end
            default: w_nxt_state = S_REQ;
        endcase
        if (commit_mis_pred) begin
            w_nxt_state = S_REQ;
            w_nxt_pc    = commit_target_PC;
            w_capture   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_pkt   <= '0;
            r_call  <= 1'b0;
            r_ret   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_pc    <= w_nxt_pc;
            if (w_capture) begin
                r_pkt.inst       <= icache_rsp_inst;
                r_pkt.PC         <= w_req_addr;
                r_pkt.NPC        <= w_pd_npc;
                r_pkt.pred_taken <= w_pd_taken;
                r_call           <= w_pd_call;
                r_ret            <= w_pd_ret;
            end
        end
    end

    assign icache_req_addr = w_req_addr;
    assign if_valid        = (r_state == S_VALID);
    assign if_inst         = r_pkt.inst;
    assign if_PC           = r_pkt.PC;
    assign if_NPC          = r_pkt.NPC;
    assign if_pred_taken   = r_pkt.pred_taken;
    assign ras_push_enable = w_push;
    assign ras_pop_enable  = w_pop;
    assign jal_PC_plus_4   = r_pkt.PC + XLEN'(4);

endmodule

// File: tb/tb_fetch_next_pc.sv
// Bench for fetch_next_pc: table of single-instruction vectors plus hand-written
// stall, mispredict, stream and mid-operation reset sequences.
module tb_fetch_next_pc;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] icache_req_addr;
    logic        icache_rsp_valid;
    logic [31:0] icache_rsp_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_PC;
    logic [31:0] if_NPC;
    logic        if_pred_taken;
    logic        ras_push_enable;
    logic        ras_pop_enable;
    logic [31:0] jal_PC_plus_4;
    logic        read_from_ras;
    logic [31:0] jal_ret_addr;
    logic        commit_mis_pred;
    logic [31:0] commit_target_PC;

    always #5 clock = ~clock;

    fetch_next_pc #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clock            (clock),
        .reset            (reset),
        .icache_req_addr  (icache_req_addr),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_inst  (icache_rsp_inst),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_inst          (if_inst),
        .if_PC            (if_PC),
        .if_NPC           (if_NPC),
        .if_pred_taken    (if_pred_taken),
        .ras_push_enable  (ras_push_enable),
        .ras_pop_enable   (ras_pop_enable),
        .jal_PC_plus_4    (jal_PC_plus_4),
        .read_from_ras    (read_from_ras),
        .jal_ret_addr     (jal_ret_addr),
        .commit_mis_pred  (commit_mis_pred),
        .commit_target_PC (commit_target_PC)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rras;
        logic [31:0] ret;
        logic [31:0] npc;
        logic        taken;
        logic        push;
        logic        pop;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        taken;
        logic        push;
        logic        pop;
    } exp_t;

    localparam logic [31:0] JAL_X1_P100  = 32'h100000EF;
    localparam logic [31:0] RET_X1       = 32'h00008067;
    localparam logic [31:0] RET_X5       = 32'h00028067;
    localparam logic [31:0] BEQ_M8       = 32'hFE000CE3;
    localparam logic [31:0] BEQ_P8       = 32'h00000463;
    localparam logic [31:0] JALR_X1_X5   = 32'h000280E7;
    localparam logic [31:0] JALR_X1_X1   = 32'h000080E7;
    localparam logic [31:0] NOP          = 32'h00000013;
    localparam logic [31:0] JAL_X0_M8    = 32'hFF9FF06F;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        commit_mis_pred  = 1'b1;
        commit_target_PC = pc;
        if_ready         = 1'b0;
        icache_rsp_valid = 1'b0;
        tick();
        commit_mis_pred  = 1'b0;
        #1;
        chk("redirect_addr", icache_req_addr, pc);
        chk1("redirect_valid", if_valid, 1'b0);
    endtask

    // Offers an I-cache hit this cycle and records what dispatch should see.
    task automatic present(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] npc,
                           input logic taken, input logic push, input logic pop);
        exp_t e;
        icache_rsp_valid = 1'b1;
        icache_rsp_inst  = inst;
        e.inst = inst; e.pc = pc; e.npc = npc; e.taken = taken; e.push = push; e.pop = pop;
        exp_q.push_back(e);
        #1;
        chk("hit_addr", icache_req_addr, pc);
    endtask

    task automatic check_held(output exp_t e);
        chk1("held_valid", if_valid, 1'b1);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got none expected entry");
            e = '{default: '0};
        end else begin
            e = exp_q.pop_front();
            chk("held_inst", if_inst, e.inst);
            chk("held_pc", if_PC, e.pc);
            chk("held_npc", if_NPC, e.npc);
            chk1("held_taken", if_pred_taken, e.taken);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit do_redir);
        exp_t e;
        read_from_ras = v.rras;
        jal_ret_addr  = v.ret;
        if (do_redir) redirect(v.pc);
        present(v.inst, v.pc, v.npc, v.taken, v.push, v.pop);
        tick();
        icache_rsp_valid = 1'b0;
        #1;
        check_held(e);
        chk1("idle_push", ras_push_enable, 1'b0);
        chk1("idle_pop", ras_pop_enable, 1'b0);
        if_ready = 1'b1;
        #1;
        chk1("fire_push", ras_push_enable, e.push);
        chk1("fire_pop", ras_pop_enable, e.pop);
        if (e.push) chk("pc_plus_4", jal_PC_plus_4, v.pc + 32'd4);
        tick();
        if_ready = 1'b0;
        #1;
        chk("next_addr", icache_req_addr, e.npc);
        chk1("after_fire_valid", if_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   fires;
        vecs[0] = '{32'h000, JAL_X1_P100, 1'b0, 32'h0,    32'h100,      1'b1, 1'b1, 1'b0};
        vecs[1] = '{32'h200, RET_X1,      1'b1, 32'h4,    32'h4,        1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h200, RET_X1,      1'b0, 32'h4,    32'h204,      1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h040, BEQ_M8,      1'b0, 32'h0,    32'h38,       1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h040, BEQ_P8,      1'b0, 32'h0,    32'h44,       1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h300, JALR_X1_X5,  1'b0, 32'h0,    32'h304,      1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h300, JALR_X1_X1,  1'b1, 32'h40,   32'h304,      1'b0, 1'b1, 1'b0};
        vecs[7] = '{32'h010, NOP,         1'b1, 32'h40,   32'h14,       1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h000, JAL_X0_M8,   1'b0, 32'h0,    32'hFFFFFFF8, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'h500, RET_X5,      1'b1, 32'h1234, 32'h1234,     1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        icache_rsp_valid = 1'b0; icache_rsp_inst = 32'h0;
        if_ready = 1'b1; read_from_ras = 1'b1; jal_ret_addr = 32'h0;
        commit_mis_pred = 1'b0; commit_target_PC = 32'h0;
        #2;
        chk("rst_addr", icache_req_addr, 32'h0);
        chk1("rst_valid", if_valid, 1'b0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_PC, 32'h0);
        chk("rst_npc", if_NPC, 32'h0);
        chk1("rst_taken", if_pred_taken, 1'b0);
        chk1("rst_push", ras_push_enable, 1'b0);
        chk1("rst_pop", ras_pop_enable, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        if_ready = 1'b0;
        #1;
        chk("post_rst_addr", icache_req_addr, 32'h0);

        // First fetch straight out of reset, no redirect.
        run_vec(vecs[0], 1'b0);
        for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b1);

        // Dispatch stalls for three cycles on a held call.
        read_from_ras = 1'b0;
        redirect(32'h300);
        present(JAL_X1_P100, 32'h300, 32'h400, 1'b1, 1'b1, 1'b0);
        tick();
        icache_rsp_valid = 1'b0;
        #1;
        check_held(e);
        for (int i = 0; i < 3; i++) begin
            chk1("stall_push", ras_push_enable, 1'b0);
            chk1("stall_valid", if_valid, 1'b1);
            chk("stall_npc", if_NPC, 32'h400);
            chk("stall_pc", if_PC, 32'h300);
            tick();
        end
        if_ready = 1'b1;
        #1;
        chk1("stall_fire_push", ras_push_enable, 1'b1);
        tick();
        #1;
        chk1("stall_single_push", ras_push_enable, 1'b0);
        chk("stall_next_addr", icache_req_addr, 32'h400);
        if_ready = 1'b0;

        // Mispredict collides with a call that would otherwise fire.
        redirect(32'h300);
        present(JAL_X1_P100, 32'h300, 32'h400, 1'b1, 1'b1, 1'b0);
        tick();
        icache_rsp_valid = 1'b0;
        #1;
        check_held(e);
        if_ready = 1'b1;
        commit_mis_pred = 1'b1;
        commit_target_PC = 32'h80;
        #1;
        chk1("mp_push", ras_push_enable, 1'b0);
        tick();
        commit_mis_pred = 1'b0;
        if_ready = 1'b0;
        #1;
        chk1("mp_valid", if_valid, 1'b0);
        chk("mp_addr", icache_req_addr, 32'h80);

        // Back-to-back hits then a miss.
        redirect(32'h0);
        present(NOP | (32'd0 << 20), 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
        tick();
        fires = 0;
        for (int k = 1; k <= 4; k++) begin
            if_ready = 1'b1;
            if (k < 4) begin
                present(NOP | (32'(k) << 20), 32'(4 * k), 32'(4 * k + 4), 1'b0, 1'b0, 1'b0);
            end else begin
                icache_rsp_valid = 1'b0;
                #1;
                chk("stream_addr", icache_req_addr, 32'h10);
            end
            check_held(e);
            chk("stream_pc", e.pc, 32'(4 * (k - 1)));
            chk1("stream_push", ras_push_enable, 1'b0);
            if (if_valid && if_ready) fires++;
            tick();
        end
        chk("stream_fires", 32'(fires), 32'd4);
        if_ready = 1'b0;
        #1;
        chk1("miss_bubble", if_valid, 1'b0);
        chk("miss_addr", icache_req_addr, 32'h10);
        present(NOP, 32'h10, 32'h14, 1'b0, 1'b0, 1'b0);
        tick();
        icache_rsp_valid = 1'b0;
        #1;
        check_held(e);

        // Reset arrives while a call is about to dispatch.
        redirect(32'h300);
        present(JAL_X1_P100, 32'h300, 32'h400, 1'b1, 1'b1, 1'b0);
        tick();
        icache_rsp_valid = 1'b0;
        if_ready = 1'b1;
        #1;
        check_held(e);
        chk1("pre_rst_push", ras_push_enable, 1'b1);
        reset = 1'b1;
        #1;
        chk1("midrst_push", ras_push_enable, 1'b0);
        chk1("midrst_valid", if_valid, 1'b0);
        chk("midrst_addr", icache_req_addr, 32'h0);
        chk("midrst_npc", if_NPC, 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
